// File: rtl/pipo_lsr_rx.sv
// pipo_lsr_rx: MSB-first serial-to-parallel receiver with a double-buffered
// Valid/Ready output and sticky overrun / frame-error flags.
module pipo_lsr_rx #(
    parameter int unsigned BITS = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            Shift,
    input  logic            Start,
    input  logic            In,
    input  logic            Ready,
    input  logic            Clear,
    output logic [BITS-1:0] out,
    output logic            Valid,
    output logic            Busy,
    output logic            Overrun,
    output logic            FrameErr
);

    localparam int unsigned CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t          state;
    logic [BITS-1:0] sr;
    logic [CW-1:0]   cnt;

    logic [BITS-1:0] word;
    logic            complete;
    logic            abort;
    logic            ovr_set;

    // Word as it would stand after shifting in the current bit.
    assign word     = {sr[BITS-2:0], In};
    assign complete = (state == StShift) && Shift && !Start && (cnt == LAST);
    assign abort    = (state == StShift) && Shift && Start;
    // A finished word with the buffer still full and not being consumed is lost.
    assign ovr_set  = complete && Valid && !Ready;
    assign Busy     = (state == StShift);

    // Receive FSM: shift register, bit counter and frame state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= StIdle;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (Shift && Start) begin
                        sr    <= word;
                        cnt   <= ONE;
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (Shift) begin
                        sr <= word;
                        if (Start) begin
                            // Abandon the partial word; this bit starts a new one.
                            cnt <= ONE;
                        end else if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= StIdle;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Output buffer: load on completion unless an unconsumed word is held.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out   <= '0;
            Valid <= 1'b0;
        end else if (complete) begin
            if (!Valid || Ready) begin
                out <= word;
            end
            Valid <= 1'b1;
        end else if (Valid && Ready) begin
            Valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event beats a simultaneous Clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Overrun  <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            Overrun  <= ovr_set | (Overrun & ~Clear);
            FrameErr <= abort | (FrameErr & ~Clear);
        end
    end

endmodule

// File: tb/tb_pipo_lsr_rx.sv
// Bench for pipo_lsr_rx: a 4-bit and an 8-bit instance share one stimulus
// stream and are compared every cycle against a word-level reference model.
module tb_pipo_lsr_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic sh, st, din, rdy, clr;

    logic [3:0] out4;
    logic       v4, b4, o4, f4;
    logic [7:0] out8;
    logic       v8, b8, o8, f8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipo_lsr_rx #(.BITS(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .Shift(sh), .Start(st), .In(din), .Ready(rdy),
        .Clear(clr), .out(out4), .Valid(v4), .Busy(b4), .Overrun(o4), .FrameErr(f4)
    );

    pipo_lsr_rx #(.BITS(8)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .Shift(sh), .Start(st), .In(din), .Ready(rdy),
        .Clear(clr), .out(out8), .Valid(v8), .Busy(b8), .Overrun(o8), .FrameErr(f8)
    );

    // Reference model, index 0 = 4-bit instance, index 1 = 8-bit instance.
    int          m_w [2] = '{4, 8};
    bit          m_frame [2];
    int          m_n [2];
    int          m_acc [2];
    logic [31:0] m_out [2];
    bit          m_valid [2];
    bit          m_ovr [2];
    bit          m_fe [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_frame[i] = 0; m_n[i] = 0; m_acc[i] = 0; m_out[i] = '0;
            m_valid[i] = 0; m_ovr[i] = 0; m_fe[i] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            bit done = 0;
            bit fe_set = 0;
            bit ov_set = 0;
            int word = 0;
            if (sh) begin
                if (st) begin
                    if (m_frame[i]) fe_set = 1;
                    m_frame[i] = 1;
                    m_n[i] = 1;
                    m_acc[i] = int'(din);
                end else if (m_frame[i]) begin
                    m_acc[i] = m_acc[i] * 2 + int'(din);
                    m_n[i] = m_n[i] + 1;
                    if (m_n[i] == m_w[i]) begin
                        done = 1;
                        word = m_acc[i];
                        m_frame[i] = 0;
                        m_n[i] = 0;
                    end
                end
            end
            if (done) begin
                if (!m_valid[i] || rdy) begin
                    m_out[i] = 32'(word);
                    m_valid[i] = 1;
                end else begin
                    ov_set = 1;
                end
            end else if (m_valid[i] && rdy) begin
                m_valid[i] = 0;
            end
            m_ovr[i] = ov_set | (m_ovr[i] & !clr);
            m_fe[i] = fe_set | (m_fe[i] & !clr);
        end
    endfunction

    // One clock: advance the model with the inputs the DUT sampled, then compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checks += 10;
        if (out4 !== m_out[0][3:0]) begin
            failures++; $display("FAIL model out4 got %h exp %h", out4, m_out[0][3:0]);
        end
        if (v4 !== m_valid[0]) begin
            failures++; $display("FAIL model valid4 got %b exp %b", v4, m_valid[0]);
        end
        if (b4 !== m_frame[0]) begin
            failures++; $display("FAIL model busy4 got %b exp %b", b4, m_frame[0]);
        end
        if (o4 !== m_ovr[0]) begin
            failures++; $display("FAIL model overrun4 got %b exp %b", o4, m_ovr[0]);
        end
        if (f4 !== m_fe[0]) begin
            failures++; $display("FAIL model frameerr4 got %b exp %b", f4, m_fe[0]);
        end
        if (out8 !== m_out[1][7:0]) begin
            failures++; $display("FAIL model out8 got %h exp %h", out8, m_out[1][7:0]);
        end
        if (v8 !== m_valid[1]) begin
            failures++; $display("FAIL model valid8 got %b exp %b", v8, m_valid[1]);
        end
        if (b8 !== m_frame[1]) begin
            failures++; $display("FAIL model busy8 got %b exp %b", b8, m_frame[1]);
        end
        if (o8 !== m_ovr[1]) begin
            failures++; $display("FAIL model overrun8 got %b exp %b", o8, m_ovr[1]);
        end
        if (f8 !== m_fe[1]) begin
            failures++; $display("FAIL model frameerr8 got %b exp %b", f8, m_fe[1]);
        end
    endtask

    // Send n bits of value MSB first, Start on the first, gap idle cycles after each bit.
    task automatic send_bits(input logic [7:0] value, input int n, input int gap);
        for (int k = n - 1; k >= 0; k--) begin
            sh = 1'b1;
            st = (k == n - 1);
            din = value[k];
            tick();
            sh = 1'b0;
            st = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
        sh = 1'b0;
        st = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sh = 0; st = 0; din = 0; rdy = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out4, v4, b4, o4, f4, out8, v8, b8, o8, f8} !== 20'h0) begin
            failures++;
            $display("FAIL reset outputs got %h exp 0",
                     {out4, v4, b4, o4, f4, out8, v8, b8, o8, f8});
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        logic [3:0] bits = 4'b1011;
        rdy = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            sh = 1'b1;
            st = (k == 3);
            din = bits[k];
            tick();
            if (b4) busy_cnt++;
        end
        sh = 1'b0; st = 1'b0;
        checks++;
        if (out4 !== 4'hB || v4 !== 1'b1) begin
            failures++; $display("FAIL basic word got %h/%b exp b/1", out4, v4);
        end
        checks++;
        if (busy_cnt != 3) begin
            failures++; $display("FAIL basic busy cycles got %0d exp 3", busy_cnt);
        end
        tick();
        checks++;
        if (v4 !== 1'b0) begin
            failures++; $display("FAIL basic valid one cycle got %b exp 0", v4);
        end
    endtask

    task automatic test_overrun();
        rdy = 1'b0;
        send_bits(8'h0B, 4, 0);
        send_bits(8'h06, 4, 0);
        checks++;
        if (out4 !== 4'hB || v4 !== 1'b1 || o4 !== 1'b1) begin
            failures++;
            $display("FAIL overrun got out=%h v=%b ovr=%b exp b/1/1", out4, v4, o4);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (o4 !== 1'b0 || out4 !== 4'hB || v4 !== 1'b1) begin
            failures++;
            $display("FAIL overrun clear got ovr=%b out=%h v=%b exp 0/b/1", o4, out4, v4);
        end
    endtask

    task automatic test_ready_same_cycle();
        logic [3:0] bits = 4'h6;
        rdy = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            sh = 1'b1;
            st = (k == 3);
            din = bits[k];
            rdy = (k == 0);
            tick();
        end
        sh = 1'b0; st = 1'b0;
        checks++;
        if (out4 !== 4'h6 || v4 !== 1'b1 || o4 !== 1'b0) begin
            failures++;
            $display("FAIL ready_same got out=%h v=%b ovr=%b exp 6/1/0", out4, v4, o4);
        end
        tick();
        rdy = 1'b0;
        checks++;
        if (v4 !== 1'b0 || out4 !== 4'h6) begin
            failures++; $display("FAIL ready_same drain got v=%b out=%h exp 0/6", v4, out4);
        end
    endtask

    task automatic test_frame_err();
        rdy = 1'b1;
        send_bits(8'h02, 2, 0);
        send_bits(8'h06, 4, 0);
        checks++;
        if (f4 !== 1'b1 || out4 !== 4'h6 || v4 !== 1'b1) begin
            failures++;
            $display("FAIL frame_err got fe=%b out=%h v=%b exp 1/6/1", f4, out4, v4);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (f4 !== 1'b0) begin
            failures++; $display("FAIL frame_err clear got %b exp 0", f4);
        end
    endtask

    task automatic test_idle_and_gaps();
        rdy = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            sh = 1'b1; st = 1'b0; din = 1'b1;
            tick();
            checks++;
            if (b4 !== 1'b0 || v4 !== 1'b0) begin
                failures++; $display("FAIL idle_shift got busy=%b v=%b exp 0/0", b4, v4);
            end
        end
        sh = 1'b0;
        rdy = 1'b0;
        send_bits(8'h0B, 4, 3);
        checks++;
        if (out4 !== 4'hB || v4 !== 1'b1 || b4 !== 1'b0 || f4 !== 1'b0) begin
            failures++;
            $display("FAIL gaps got out=%h v=%b busy=%b fe=%b exp b/1/0/0", out4, v4, b4, f4);
        end
        rdy = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_word8();
        rdy = 1'b1;
        send_bits(8'h15, 5, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (b8 !== 1'b0 || v8 !== 1'b0 || out8 !== 8'h00) begin
            failures++;
            $display("FAIL reset8 async got busy=%b v=%b out=%h exp 0/0/00", b8, v8, out8);
        end
        #2 rst_n = 1'b1;
        send_bits(8'hA5, 8, 0);
        checks++;
        if (out8 !== 8'hA5 || v8 !== 1'b1 || o8 !== 1'b0 || f8 !== 1'b0) begin
            failures++;
            $display("FAIL reset8 word got out=%h v=%b ovr=%b fe=%b exp a5/1/0/0",
                     out8, v8, o8, f8);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            sh  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 7) == 0);
            din = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        sh = 0; st = 0; rdy = 0; clr = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_ready_same_cycle();
        test_frame_err();
        test_idle_and_gaps();
        test_reset_mid_word8();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipo_lsr_rx.md
# pipo_lsr_rx

Serial-to-parallel receiver for the MSB-first stream produced by the team's parallel-load left-shift register: one bit per `Shift` strobe, a `Start` qualifier marking the first (most significant) bit of each word. Completed words are moved into a separate output buffer and offered through a Valid/Ready handshake, so reception of the next word overlaps consumption of the current one. Sticky error flags report dropped words and aborted frames.

## Interface
- `BITS`, 4, word width; legal range 2..32.
- `CLK`  in  1  rising-edge clock; all state changes on its rising edge except reset.
- `RST_N`  in  1  asynchronous, active-low reset.
- `Shift`  in  1  bit strobe; `In` and `Start` are sampled only when `Shift`=1.
- `Start`  in  1  marks the bit on `In` as the first (MSB) bit of a word.
- `In`  in  1  serial data bit.
- `Ready`  in  1  consumer accepts `out` when `Valid`=1 and `Ready`=1.
- `Clear`  in  1  synchronous clear of `Overrun` and `FrameErr`.
- `out`  out  BITS  received word, MSB = first bit received.
- `Valid`  out  1  `out` holds an unconsumed word.
- `Busy`  out  1  FSM is in SHIFT (a word is partially received).
- `Overrun`  out  1  sticky: a completed word was dropped.
- `FrameErr`  out  1  sticky: a partial word was aborted by a new `Start`.

## Operation
- Internal: shift register `sr[BITS-1:0]`, bit counter `cnt` of width clog2(BITS+1), FSM state {IDLE, SHIFT}.
- IDLE: `Shift`=1 and `Start`=1 -> `sr` <= {`sr[BITS-2:0]`, `In`}, `cnt` <= 1, go to SHIFT. `Shift`=1 and `Start`=0 -> bit discarded, stay in IDLE. `Shift`=0 -> nothing.
- SHIFT, `Shift`=1, `Start`=0: `sr` <= {`sr[BITS-2:0]`, `In`}, `cnt` <= `cnt`+1. When `cnt`=BITS-1 this is the final bit: the completed word {`sr[BITS-2:0]`, `In`} is delivered (below), `cnt` <= 0, go to IDLE.
- SHIFT, `Shift`=1, `Start`=1: partial word abandoned; `FrameErr` <= 1; the bit is treated as a new first bit (`cnt` <= 1, stay in SHIFT).
- SHIFT, `Shift`=0: hold all state; no timeout.
- Delivery on a completing edge:
  - `Valid`=0, or `Valid`=1 and `Ready`=1: `out` <= word, `Valid` <= 1.
  - `Valid`=1 and `Ready`=0: word dropped, `out` unchanged, `Valid` stays 1, `Overrun` <= 1.
- Handshake: with `Valid`=1 and `Ready`=1 and no completion on the same edge, `Valid` <= 0 and `out` keeps its last value. `out` never changes while `Valid`=1 and `Ready`=0.
- `Clear`=1 forces `Overrun` and `FrameErr` to 0. A set event on the same edge wins, so the flag reads 1.
- `Busy` = (state == SHIFT).

## Timing
- Reset (`RST_N`=0, asynchronous): `out`=0, `Valid`=0, `Busy`=0, `Overrun`=0, `FrameErr`=0, `sr`=0, `cnt`=0, state IDLE. Reset during a partial word discards it with no flag.
- Latency: `Valid` rises on the clock edge that samples the BITS-th `Shift`. The minimum word period is BITS cycles, with `Shift` asserted every cycle.
- Back-to-back frames: `Start` may be asserted on the cycle immediately after the final bit. No gap cycle is required.
- `Ready` is sampled only while `Valid`=1. It has no effect otherwise and needs no combinational path to any output.
- All outputs are registered except `Busy`, which is decoded from the state register.

## Test plan
- BITS=4: reset, then `Shift` every cycle with `Start` on the first bit, `In`=1,0,1,1, `Ready`=1 -> `out`=4'hB, with `Valid` high for one cycle at the 4th sampling edge; `Busy` high for 3 cycles.
- BITS=4: `Ready`=0, send 4'hB then 4'h6 back-to-back -> `out` stays 4'hB, `Valid`=1, `Overrun`=1; pulse `Clear` -> `Overrun`=0.
- BITS=4: `Ready`=1 in the same cycle the second word completes -> `out` goes 4'hB -> 4'h6, `Valid` stays 1, `Overrun`=0.
- BITS=4: send two bits of a word, then `Start` with bits 0,1,1,0 -> `FrameErr`=1, `out`=4'h6, `Valid`=1.
- BITS=4: `Shift` pulsed with `Start`=0 while in IDLE, `In`=1 -> no state change, `Busy`=0; `Shift` gaps of 3 cycles mid-word -> same result as contiguous.
- BITS=8: assert `RST_N`=0 after 5 bits, release, then send 8'hA5 -> `out`=8'hA5 with no flags set.
